sobel_window_gen: RTL and testbench

Streaming 3x3 window generator that sits directly upstream of the Sobel gradient stage. It accepts one 8-bit grayscale pixel per valid cycle in raster order and buffers the two previous image lines. It emits three packed 24-bit rows (top, middle, bottom) that feed the Sobel stage's `row1`/`row2`/`row3` inputs, one window per accepted pixel once a full 3x3 neighbourhood exists.

---
 rtl/sobel_window_gen.sv | 92 +++++++++
 tb/tb_sobel_window_gen.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: streaming 3x3 window generator with two line buffers for a Sobel stage
module sobel_window_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sof,
  input  logic                          pix_valid,
  input  logic [7:0]                    pix_in,
  output logic [23:0]                   row1,
  output logic [23:0]                   row2,
  output logic [23:0]                   row3,
  output logic                          win_valid,
  output logic [$clog2(IMG_WIDTH)-1:0]  win_x,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_y,
  output logic                          frame_done
);
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [7:0]    r_lb0 [IMG_WIDTH];
  logic [7:0]    r_lb1 [IMG_WIDTH];
  logic [23:0]   r_row1, r_row2, r_row3;
  logic          r_win_valid, r_frame_done;
  logic [XW-1:0] r_win_x;
  logic [YW-1:0] r_win_y;
  logic [XW-1:0] w_px;
  logic [YW-1:0] w_py;
  logic          w_last_x, w_last_y, w_acc;
  logic [7:0]    w_lb0_rd, w_lb1_rd;
  // sof overrides the running position so the pixel lands at (0,0)
  always_comb begin
    w_px     = sof ? '0 : r_x;
    w_py     = sof ? '0 : r_y;
    w_last_x = (w_px == XW'(IMG_WIDTH - 1));
    w_last_y = (w_py == YW'(IMG_HEIGHT - 1));
    w_acc    = rst_n && pix_valid;
    w_lb0_rd = r_lb0[w_px];
    w_lb1_rd = r_lb1[w_px];
  end
  // raster position counters; sof alone just rewinds to the frame origin
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (pix_valid) begin
      r_x <= w_last_x ? '0 : w_px + XW'(1);
      r_y <= w_last_x ? (w_last_y ? '0 : w_py + YW'(1)) : w_py;
    end else if (sof) begin
      r_x <= '0;
      r_y <= '0;
    end
  end
  // line buffers shift one line down per column; contents survive reset and are gated by py>=2
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_lb1[w_px] <= w_lb0_rd;
      r_lb0[w_px] <= pix_in;
    end
  end
  // window shift registers and the per-window status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_row1       <= '0;
      r_row2       <= '0;
      r_row3       <= '0;
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_win_x      <= '0;
      r_win_y      <= '0;
    end else begin
      r_win_valid  <= pix_valid && (w_px >= XW'(2)) && (w_py >= YW'(2));
      r_frame_done <= pix_valid && w_last_x && w_last_y;
      if (pix_valid) begin
        r_row3  <= {r_row3[15:0], pix_in};
        r_row2  <= {r_row2[15:0], w_lb0_rd};
        r_row1  <= {r_row1[15:0], w_lb1_rd};
        r_win_x <= w_px - XW'(1);
        r_win_y <= w_py - YW'(1);
      end
    end
  end
  assign row1       = r_row1;
  assign row2       = r_row2;
  assign row3       = r_row3;
  assign win_valid  = r_win_valid;
  assign frame_done = r_frame_done;
  assign win_x      = r_win_x;
  assign win_y      = r_win_y;
endmodule

// File: tb/tb_sobel_window_gen.sv
// tb_sobel_window_gen: directed checks of the 3x3 window generator on a 4x4 image
module tb_sobel_window_gen;
  logic        clk = 0, rst_n = 0, sof = 0, pix_valid = 0;
  logic [7:0]  pix_in = 0;
  logic [23:0] row1, row2, row3;
  logic        win_valid, frame_done;
  logic [1:0]  win_x, win_y;
  int n_checks = 0, n_fail = 0;
  typedef struct packed {
    logic [23:0] r1, r2, r3;
    logic [1:0]  x, y;
    logic        fd;
  } win_t;
  win_t q[$];

  sobel_window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
    .clk(clk), .rst_n(rst_n), .sof(sof), .pix_valid(pix_valid), .pix_in(pix_in),
    .row1(row1), .row2(row2), .row3(row3), .win_valid(win_valid),
    .win_x(win_x), .win_y(win_y), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // record every presented window, sampled away from the active edge
  always @(negedge clk) if (win_valid === 1'b1) q.push_back('{row1, row2, row3, win_x, win_y, frame_done});

  function automatic logic [7:0] pv(input int b, input int x, input int y);
    return 8'(b + 16 * y + x);
  endfunction

  function automatic logic [23:0] er(input int b, input int cx, input int r);
    return {pv(b, cx - 1, r), pv(b, cx, r), pv(b, cx + 1, r)};
  endfunction

  task automatic send_pix(input logic [7:0] v, input logic s);
    @(negedge clk);
    pix_valid = 1; pix_in = v; sof = s;
    @(posedge clk); #1;
    pix_valid = 0; sof = 0;
  endtask

  task automatic send_frame(input int b, input int maxgap, input logic s0);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) begin
        if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(posedge clk);
        send_pix(pv(b, x, y), s0 && x == 0 && y == 0);
      end
  endtask

  task automatic test_reset;
    rst_n = 0; pix_valid = 1; sof = 1; pix_in = 8'hAA;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (row1 !== 24'h0) begin n_fail++; $display("FAIL reset_row1 got %h want 000000", row1); end
    n_checks++; if (row2 !== 24'h0) begin n_fail++; $display("FAIL reset_row2 got %h want 000000", row2); end
    n_checks++; if (row3 !== 24'h0) begin n_fail++; $display("FAIL reset_row3 got %h want 000000", row3); end
    n_checks++; if (win_valid !== 1'b0) begin n_fail++; $display("FAIL reset_win_valid got %b want 0", win_valid); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    n_checks++; if (win_x !== 2'd0 || win_y !== 2'd0) begin n_fail++; $display("FAIL reset_win_xy got %0d,%0d want 0,0", win_x, win_y); end
    rst_n = 1; pix_valid = 0; sof = 0;
    repeat (2) @(posedge clk);
    n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL reset_no_window got %0d windows want 0", q.size()); end
  endtask

  task automatic test_continuous;
    q.delete();
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) begin
        send_pix(pv(0, x, y), x == 0 && y == 0);
        if (x == 3 && y == 1) begin
          n_checks++; if (win_valid !== 1'b0) begin n_fail++; $display("FAIL line1_gate win_valid got %b want 0", win_valid); end
        end
        if (x == 1 && y == 2) begin
          n_checks++; if (win_valid !== 1'b0) begin n_fail++; $display("FAIL col1_gate win_valid got %b want 0", win_valid); end
        end
        if (x == 2 && y == 2) begin
          n_checks++; if (win_valid !== 1'b1) begin n_fail++; $display("FAIL first_win_valid got %b want 1", win_valid); end
          n_checks++; if ({row1, row2, row3} !== {24'h000102, 24'h101112, 24'h202122})
            begin n_fail++; $display("FAIL first_win_rows got %h %h %h want 000102 101112 202122", row1, row2, row3); end
          n_checks++; if (win_x !== 2'd1 || win_y !== 2'd1) begin n_fail++; $display("FAIL first_win_xy got %0d,%0d want 1,1", win_x, win_y); end
          n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL first_win_fd got %b want 0", frame_done); end
        end
      end
    n_checks++; if ({row1, row2, row3} !== {24'h111213, 24'h212223, 24'h313233})
      begin n_fail++; $display("FAIL last_win_rows got %h %h %h want 111213 212223 313233", row1, row2, row3); end
    n_checks++; if (win_valid !== 1'b1 || frame_done !== 1'b1)
      begin n_fail++; $display("FAIL last_win_pulse got wv=%b fd=%b want 1 1", win_valid, frame_done); end
    @(posedge clk); #1;
    n_checks++; if (win_valid !== 1'b0 || frame_done !== 1'b0)
      begin n_fail++; $display("FAIL idle_pulse_end got wv=%b fd=%b want 0 0", win_valid, frame_done); end
    n_checks++; if (row3 !== 24'h313233 || win_x !== 2'd2) begin n_fail++; $display("FAIL idle_hold got row3=%h x=%0d want 313233 2", row3, win_x); end
    @(posedge clk);
    n_checks++; if (q.size() != 4) begin n_fail++; $display("FAIL cont_count got %0d want 4", q.size()); end
    for (int i = 0; i < q.size() && i < 4; i++) begin
      n_checks++; if (q[i].x !== 2'(1 + i % 2) || q[i].y !== 2'(1 + i / 2))
        begin n_fail++; $display("FAIL cont_order[%0d] got %0d,%0d want %0d,%0d", i, q[i].x, q[i].y, 1 + i % 2, 1 + i / 2); end
    end
  endtask

  task automatic test_gaps;
    q.delete();
    send_frame(0, 3, 1'b1);
    repeat (3) @(posedge clk);
    n_checks++; if (q.size() != 4) begin n_fail++; $display("FAIL gaps_count got %0d want 4", q.size()); end
    for (int i = 0; i < q.size() && i < 4; i++) begin
      n_checks++;
      if (q[i] !== '{er(0, 1 + i % 2, i / 2), er(0, 1 + i % 2, 1 + i / 2), er(0, 1 + i % 2, 2 + i / 2), 2'(1 + i % 2), 2'(1 + i / 2), 1'(i == 3)})
        begin n_fail++; $display("FAIL gaps_win[%0d] got %h %h %h x=%0d y=%0d fd=%b", i, q[i].r1, q[i].r2, q[i].r3, q[i].x, q[i].y, q[i].fd); end
    end
  endtask

  task automatic test_mid_reset;
    for (int i = 0; i < 10; i++) send_pix(pv(0, i % 4, i / 4), i == 0);
    @(negedge clk); rst_n = 0;
    @(posedge clk); #1; rst_n = 1;
    n_checks++; if ({row1, row2, row3, win_valid, win_x, win_y, frame_done} !== '0)
      begin n_fail++; $display("FAIL midreset_zero got %h %h %h wv=%b x=%0d y=%0d fd=%b want all 0", row1, row2, row3, win_valid, win_x, win_y, frame_done); end
    q.delete();
    send_frame(0, 0, 1'b0);
    repeat (2) @(posedge clk);
    n_checks++; if (q.size() != 4) begin n_fail++; $display("FAIL midreset_count got %0d want 4", q.size()); end
    n_checks++; if (q.size() == 0 || q[0] !== '{24'h000102, 24'h101112, 24'h202122, 2'd1, 2'd1, 1'b0})
      begin n_fail++; $display("FAIL midreset_first got %h want 000102/101112/202122 at 1,1", q.size() ? q[0] : '0); end
  endtask

  task automatic test_sof_mid;
    q.delete();
    for (int i = 0; i < 10; i++) send_pix(pv(0, i % 4, i / 4), i == 0);
    send_pix(8'h55, 1'b1);
    n_checks++; if (win_valid !== 1'b0) begin n_fail++; $display("FAIL sof_pix_window got %b want 0", win_valid); end
    for (int i = 1; i < 16; i++) send_pix(pv(0, i % 4, i / 4), 1'b0);
    repeat (2) @(posedge clk);
    n_checks++; if (q.size() != 4) begin n_fail++; $display("FAIL sof_count got %0d want 4", q.size()); end
    n_checks++; if (q.size() == 0 || q[0] !== '{24'h550102, 24'h101112, 24'h202122, 2'd1, 2'd1, 1'b0})
      begin n_fail++; $display("FAIL sof_first got %h want 550102/101112/202122 at 1,1", q.size() ? q[0] : '0); end
    n_checks++; if (q.size() < 2 || q[1].x !== 2'd2 || q[1].y !== 2'd1)
      begin n_fail++; $display("FAIL sof_second got %h want centre 2,1", q.size() > 1 ? q[1] : '0); end
  endtask

  task automatic test_back_to_back;
    q.delete();
    send_frame(0, 0, 1'b1);
    send_frame(8'h80, 0, 1'b0);
    repeat (2) @(posedge clk);
    n_checks++; if (q.size() != 8) begin n_fail++; $display("FAIL b2b_count got %0d want 8", q.size()); end
    n_checks++; if (q.size() < 5 || q[4] !== '{24'h808182, 24'h909192, 24'hA0A1A2, 2'd1, 2'd1, 1'b0})
      begin n_fail++; $display("FAIL b2b_first got %h want 808182/909192/A0A1A2 at 1,1", q.size() > 4 ? q[4] : '0); end
    n_checks++; if (q.size() < 8 || q[3].fd !== 1'b1 || q[7].fd !== 1'b1 || q[7].r3 !== 24'hB1B2B3)
      begin n_fail++; $display("FAIL b2b_frame_done got %h / %h want fd on windows 3 and 7", q.size() > 3 ? q[3] : '0, q.size() > 7 ? q[7] : '0); end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_gaps();
    test_mid_reset();
    test_sof_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
